branch_resolve_unit: RTL
========================

Name: branch_resolve_unit

Overview:
Parametrised successor to the odd-pipe branch unit. Takes one decoded odd-pipe instruction per handshake, resolves BR/BRA/BRZ/BRNZ (plus the optional halfword forms), and registers the result. On a taken branch it redirects the local-store fetch address and holds a multi-cycle flush to downstream units. It sits between SPU_decode/register file and the local store address mux, in place of the single-cycle unit.

Parameters:
ADDR_W, 7, local-store word address width; all PC/target arithmetic is modulo 2^ADDR_W.
DATA_W, 128, register operand width; must be a multiple of 32.
PREF_SLOT, 3, 32-bit word index in ra_data_odd tested by conditional branches; must satisfy 0 <= PREF_SLOT < DATA_W/32; the default selects bits [96:127].
FLUSH_CYCLES, 2, cycles that flush stays high after a taken branch; 0 means no FLUSH state.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  decode presents an odd-pipe instruction
in_ready  out  1  unit can accept this cycle
inst_in_odd  in  32  instruction; opcode in [0:8], I16 in [9:24]
op_9_odd  in  1  opcode is a 9-bit-format branch
branch_number  in  1  0 = older instruction of the issue pair
pc_in  in  ADDR_W  word address of this instruction
ra_data_odd  in  DATA_W  RA operand
addr_inst_ip  in  ADDR_W  sequential fetch address from top level
branch_taken  out  1  one-cycle taken pulse
unit_reset  out  1  partner-pipe kill pulse
op_addr  out  ADDR_W  address to local store
res_valid  out  1  one-cycle pulse: resolution result valid
flush  out  1  downstream flush level
busy  out  1  state != IDLE

Behaviour:
- Reset (sampled at the clk edge): state=IDLE, all stage registers cleared, flush counter=0. branch_taken, unit_reset, res_valid, flush and busy are all 0, op_addr=0 while reset is high, and in_ready=0 while reset is high.
- FSM states IDLE, RESOLVE, FLUSH. in_ready=1 only in IDLE. busy=1 in RESOLVE and FLUSH.
- IDLE: if in_valid is high, latch inst, op_9_odd, branch_number, pc_in and ra_data_odd, then go to RESOLVE. If in_valid is low, remain in IDLE.
- RESOLVE lasts one cycle and computes:
  - imm = sign-extended I16, truncated to ADDR_W bits.
  - rel = pc + imm (mod 2^ADDR_W).
  - seq = pc + 1 (mod 2^ADDR_W).
  - cond word = ra[32*PREF_SLOT +: 32].
  - Taken rules: BRA is always taken, target imm. BR is always taken, target rel. BRZ is taken if cond word == 0, target rel. BRNZ is taken if cond word != 0, target rel.
  - If op_9_odd=0, or the opcode is unmatched, the result is not taken.
- At the RESOLVE edge, register the result. In the following cycle:
  - res_valid=1.
  - branch_taken=1 if taken.
  - unit_reset=1 if taken and branch_number==0.
- Next state after RESOLVE: FLUSH if taken and FLUSH_CYCLES>0, otherwise IDLE.
- Latency: accept at edge N. res_valid and branch_taken are visible in cycle N+2 for exactly one cycle. in_ready returns in cycle N+2 if not taken or FLUSH_CYCLES=0, otherwise in cycle N+2+FLUSH_CYCLES.
- op_addr is the registered target in the branch_taken cycle, otherwise addr_inst_ip (combinational pass-through).
- FLUSH: flush=1, down-counter loaded with FLUSH_CYCLES-1 on entry, decremented each cycle. Exit to IDLE when the counter is 0. Total flush duration is exactly FLUSH_CYCLES cycles, beginning in the cycle after branch_taken.
- The not-taken path produces a res_valid pulse only: no flush, op_addr follows addr_inst_ip.
- Reset in RESOLVE or FLUSH aborts immediately. The result is never emitted, flush drops at the next edge, and the FSM goes to IDLE.
- Inputs arriving while in_ready=0 are ignored; the decoder must hold them.
- Target wrap-around is silent: e.g. ADDR_W=7, pc=127, BRZ taken with I16=1 gives target 0.

Optional Feature:
BRANCH_HALFWORD_EN. When defined, BRHZ and BRHNZ are decoded. They test the low 16 bits of the cond word (==0 / !=0 respectively), with target rel and otherwise identical timing. When undefined, those opcodes are unmatched and resolve not-taken.

Test Plan:
- BRA, I16=0x0010, pc=5, branch_number=0, FLUSH_CYCLES=2 -> in cycle N+2: branch_taken=1, unit_reset=1, op_addr=16; flush=1 for 2 cycles; in_ready back in N+4.
- BRZ, pc=10, I16=0xFFFE, ra[96:127]=0 -> taken, op_addr=8; repeat with ra[96:127]=1 -> res_valid only, branch_taken=0, op_addr=addr_inst_ip, in_ready back in N+2.
- BRNZ, branch_number=1, cond=0x80000000 -> branch_taken=1, unit_reset=0.
- Wrap: pc=127, BR with I16=1 -> op_addr=0. FLUSH_CYCLES=0 -> flush never asserts.
- Reset asserted in the RESOLVE cycle of a taken BRA -> no branch_taken/res_valid pulse; all outputs 0; in_ready=1 the cycle after reset drops.
- With BRANCH_HALFWORD_EN: BRHZ with cond=0x12340000 -> taken. Without the macro: same stimulus -> not taken.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Odd-pipe branch resolver: accepts one decoded branch per handshake, registers the outcome, redirects fetch and holds flush.
// Optional macro BRANCH_HALFWORD_EN adds BRHZ/BRHNZ decoding.
module branch_resolve_unit #(
   parameter int ADDR_W       = 7,
   parameter int DATA_W       = 128,
   parameter int PREF_SLOT    = 3,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       inst_in_odd,
   input  logic              op_9_odd,
   input  logic              branch_number,
   input  logic [ADDR_W-1:0] pc_in,
   input  logic [DATA_W-1:0] ra_data_odd,
   input  logic [ADDR_W-1:0] addr_inst_ip,
   output logic              branch_taken,
   output logic              unit_reset,
   output logic [ADDR_W-1:0] op_addr,
   output logic              res_valid,
   output logic              flush,
   output logic              busy
);

   localparam int CNT_W = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [8:0] OP_BR    = 9'h064;
   localparam logic [8:0] OP_BRA   = 9'h060;
   localparam logic [8:0] OP_BRZ   = 9'h040;
   localparam logic [8:0] OP_BRNZ  = 9'h042;
`ifdef BRANCH_HALFWORD_EN
   localparam logic [8:0] OP_BRHZ  = 9'h044;
   localparam logic [8:0] OP_BRHNZ = 9'h046;
`endif

   typedef enum logic [1:0] {IDLE, RESOLVE, FLUSH} state_t;

   state_t             state_q, state_d;
   logic [8:0]         op_q, op_d;
   logic [15:0]        i16_q, i16_d;
   logic               op9_q, op9_d;
   logic               bnum_q, bnum_d;
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [31:0]        cond_q, cond_d;
   logic               res_valid_q, res_valid_d;
   logic               taken_q, taken_d;
   logic               ureset_q, ureset_d;
   logic [ADDR_W-1:0]  target_q, target_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               flush_q, flush_d;

   logic               taken;
   logic [ADDR_W-1:0]  target;
   logic [ADDR_W-1:0]  imm;
   logic [ADDR_W-1:0]  rel;
   logic               unused_bits;

   // RT field and the non-preferred slots of RA play no part in branch resolution.
   assign unused_bits = ^{inst_in_odd[6:0], ra_data_odd};

   assign imm = ADDR_W'($signed(i16_q));
   assign rel = pc_q + imm;

   always_comb begin
      taken  = 1'b0;
      target = rel;
      if (op9_q) begin
         case (op_q)
            OP_BRA: begin
               taken  = 1'b1;
               target = imm;
            end
            OP_BR:    taken = 1'b1;
            OP_BRZ:   taken = (cond_q == 32'd0);
            OP_BRNZ:  taken = (cond_q != 32'd0);
`ifdef BRANCH_HALFWORD_EN
            OP_BRHZ:  taken = (cond_q[15:0] == 16'd0);
            OP_BRHNZ: taken = (cond_q[15:0] != 16'd0);
`endif
            default:  taken = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      i16_d       = i16_q;
      op9_d       = op9_q;
      bnum_d      = bnum_q;
      pc_d        = pc_q;
      cond_d      = cond_q;
      res_valid_d = 1'b0;
      taken_d     = 1'b0;
      ureset_d    = 1'b0;
      target_d    = target_q;
      cnt_d       = cnt_q;
      flush_d     = (state_q == FLUSH);
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               op_d    = inst_in_odd[31:23];
               i16_d   = inst_in_odd[22:7];
               op9_d   = op_9_odd;
               bnum_d  = branch_number;
               pc_d    = pc_in;
               cond_d  = ra_data_odd[32*PREF_SLOT +: 32];
               state_d = RESOLVE;
            end
         end
         RESOLVE: begin
            res_valid_d = 1'b1;
            taken_d     = taken;
            ureset_d    = taken & ~bnum_q;
            target_d    = target;
            if (taken && (FLUSH_CYCLES > 0)) begin
               state_d = FLUSH;
               cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
            end else begin
               state_d = IDLE;
            end
         end
         FLUSH: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         op_q        <= '0;
         i16_q       <= '0;
         op9_q       <= 1'b0;
         bnum_q      <= 1'b0;
         pc_q        <= '0;
         cond_q      <= '0;
         res_valid_q <= 1'b0;
         taken_q     <= 1'b0;
         ureset_q    <= 1'b0;
         target_q    <= '0;
         cnt_q       <= '0;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         i16_q       <= i16_d;
         op9_q       <= op9_d;
         bnum_q      <= bnum_d;
         pc_q        <= pc_d;
         cond_q      <= cond_d;
         res_valid_q <= res_valid_d;
         taken_q     <= taken_d;
         ureset_q    <= ureset_d;
         target_q    <= target_d;
         cnt_q       <= cnt_d;
         flush_q     <= flush_d;
      end
   end

   // Flush is delayed one cycle from the FLUSH state so it starts right after the taken pulse.
   assign in_ready     = ~reset & (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign res_valid    = res_valid_q;
   assign branch_taken = taken_q;
   assign unit_reset   = ureset_q;
   assign flush        = flush_q;
   assign op_addr      = reset ? '0 : (taken_q ? target_q : addr_inst_ip);

endmodule
